// File: rtl/lector_pkg.sv
// Shared types and constants for the BCD operand reader.
package lector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEDIR,
    ESPERAR,
    ACUMULAR,
    FIN
  } estado_lector_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest binary width able to hold 10^num_digitos - 1.
  function automatic int unsigned ancho_bin_minimo(input int unsigned num_digitos);
    longint unsigned techo;
    int unsigned     bits;
    techo = 64'd1;
    for (int unsigned i = 0; i < num_digitos; i++) techo = techo * 64'd10;
    bits = 0;
    while ((64'd1 << bits) < techo) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/acumulador_bcd.sv
// Combinational decimal accumulate step: acc*10 + digit, plus invalid-digit flag.
module acumulador_bcd
  import lector_pkg::*;
#(
  parameter int unsigned ANCHO_BIN = 10
) (
  input  logic [ANCHO_BIN-1:0] acc,
  input  logic [3:0]           digito,
  output logic [ANCHO_BIN-1:0] acc_siguiente,
  output logic                 digito_invalido
);

  always_comb begin
    acc_siguiente   = (acc << 3) + (acc << 1) + ANCHO_BIN'(digito);
    digito_invalido = (digito > BCD_MAX);
  end

endmodule

// File: rtl/lector_datos_bcd.sv
// Reads two multi-digit BCD operands from storage, one digit per request,
// and converts each to binary.
module lector_datos_bcd
  import lector_pkg::*;
#(
  parameter int unsigned NUM_DIGITOS = 3,
  parameter int unsigned ANCHO_BIN   = 10,
  parameter int unsigned LAT_LECTURA = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iniciar,
  input  logic                           cancelar,
  input  logic [3:0]                     digito_leido,
  output logic                           leer,
  output logic                           sel_numero,
  output logic [$clog2(NUM_DIGITOS)-1:0] indice_lectura,
  output logic [ANCHO_BIN-1:0]           numero1_bin,
  output logic [ANCHO_BIN-1:0]           numero2_bin,
  output logic                           ocupado,
  output logic                           listo,
  output logic                           error_bcd
);

  localparam int unsigned   IW        = $clog2(NUM_DIGITOS);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITOS - 1);
  localparam logic [1:0]    CNT_CARGA = 2'(LAT_LECTURA - 1);

  if (ANCHO_BIN < ancho_bin_minimo(NUM_DIGITOS)) begin : g_ancho_insuficiente
    $error("ANCHO_BIN too narrow for NUM_DIGITOS");
  end
  if (LAT_LECTURA < 1 || LAT_LECTURA > 3) begin : g_latencia_invalida
    $error("LAT_LECTURA must be in 1..3");
  end

  estado_lector_t       estado;
  logic [1:0]           contador;
  logic [3:0]           digito_capturado;
  logic [ANCHO_BIN-1:0] acc;
  logic [ANCHO_BIN-1:0] acc_siguiente;
  logic                 digito_invalido;

  acumulador_bcd #(
    .ANCHO_BIN(ANCHO_BIN)
  ) u_acumulador (
    .acc             (acc),
    .digito          (digito_capturado),
    .acc_siguiente   (acc_siguiente),
    .digito_invalido (digito_invalido)
  );

  // leer and listo are registered: raised on the transition into PEDIR / FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado           <= IDLE;
      contador         <= '0;
      digito_capturado <= '0;
      acc              <= '0;
      leer             <= 1'b0;
      sel_numero       <= 1'b0;
      indice_lectura   <= '0;
      numero1_bin      <= '0;
      numero2_bin      <= '0;
      ocupado          <= 1'b0;
      listo            <= 1'b0;
      error_bcd        <= 1'b0;
    end else begin
      leer  <= 1'b0;
      listo <= 1'b0;
      if (cancelar && estado != IDLE) begin
        estado      <= IDLE;
        ocupado     <= 1'b0;
        numero1_bin <= '0;
        numero2_bin <= '0;
      end else begin
        unique case (estado)
          IDLE: begin
            if (iniciar && !cancelar) begin
              estado         <= PEDIR;
              leer           <= 1'b1;
              ocupado        <= 1'b1;
              sel_numero     <= 1'b0;
              indice_lectura <= IDX_MAX;
              acc            <= '0;
              error_bcd      <= 1'b0;
            end
          end
          PEDIR: begin
            contador <= CNT_CARGA;
            estado   <= ESPERAR;
          end
          ESPERAR: begin
            if (contador == '0) begin
              digito_capturado <= digito_leido;
              estado           <= ACUMULAR;
            end else begin
              contador <= contador - 2'd1;
            end
          end
          ACUMULAR: begin
            acc <= acc_siguiente;
            if (digito_invalido) begin
              error_bcd   <= 1'b1;
              numero1_bin <= '0;
              numero2_bin <= '0;
              listo       <= 1'b1;
              estado      <= FIN;
            end else if (indice_lectura != '0) begin
              indice_lectura <= indice_lectura - IW'(1);
              leer           <= 1'b1;
              estado         <= PEDIR;
            end else if (!sel_numero) begin
              numero1_bin    <= acc_siguiente;
              acc            <= '0;
              sel_numero     <= 1'b1;
              indice_lectura <= IDX_MAX;
              leer           <= 1'b1;
              estado         <= PEDIR;
            end else begin
              numero2_bin <= acc_siguiente;
              listo       <= 1'b1;
              estado      <= FIN;
            end
          end
          FIN: begin
            estado  <= IDLE;
            ocupado <= 1'b0;
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lector_datos_bcd.sv
// Scoreboard bench for lector_datos_bcd: one instance at LAT_LECTURA=1, one at 3.
module tb_lector_datos_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cancelar, ini1, ini3;
  logic [3:0] dig1, dig3, p0, p1;
  logic       leer1, sel1, ocu1, listo1, err1;
  logic       leer3, sel3, ocu3, listo3, err3;
  logic [1:0] idx1, idx3;
  logic [9:0] a1, b1, a3, b3;
  logic [3:0] mem [2][3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct { int d; int sel; int idx; int cyc; } rd_t;
  typedef struct { int d; int n1; int n2; int err; int cyc; } res_t;
  rd_t  q_rd[$];
  res_t q_res[$];

  lector_datos_bcd #(.NUM_DIGITOS(3), .ANCHO_BIN(10), .LAT_LECTURA(1)) dut (
    .clk(clk), .rst(rst), .iniciar(ini1), .cancelar(cancelar), .digito_leido(dig1),
    .leer(leer1), .sel_numero(sel1), .indice_lectura(idx1), .numero1_bin(a1),
    .numero2_bin(b1), .ocupado(ocu1), .listo(listo1), .error_bcd(err1)
  );

  lector_datos_bcd #(.NUM_DIGITOS(3), .ANCHO_BIN(10), .LAT_LECTURA(3)) dut3 (
    .clk(clk), .rst(rst), .iniciar(ini3), .cancelar(cancelar), .digito_leido(dig3),
    .leer(leer3), .sel_numero(sel3), .indice_lectura(idx3), .numero1_bin(a3),
    .numero2_bin(b3), .ocupado(ocu3), .listo(listo3), .error_bcd(err3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Storage model: 1-cycle read for dut, 3-cycle pipeline for dut3.
  initial begin dig1 = '0; dig3 = '0; p0 = '0; p1 = '0; end
  always @(posedge clk) begin
    if (leer1) dig1 <= mem[sel1][idx1];
    if (leer3) p0 <= mem[sel3][idx3];
    p1   <= p0;
    dig3 <= p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_leer(input int d, input logic s, input logic [1:0] i);
    rd_t e;
    if (q_rd.size() == 0) begin
      checks++; failures++;
      $display("FAIL leer_unexpected dut=%0d cyc=%0d sel=%0d idx=%0d required=no strobe", d, cyc, s, i);
    end else begin
      e = q_rd.pop_front();
      check("leer_dut", d, e.d);
      check("leer_cycle", cyc, e.cyc);
      check("leer_sel", s, e.sel);
      check("leer_idx", i, e.idx);
    end
  endtask

  task automatic mon_res(input int d, input logic [9:0] n1, input logic [9:0] n2, input logic er);
    res_t e;
    if (q_res.size() == 0) begin
      checks++; failures++;
      $display("FAIL listo_unexpected dut=%0d cyc=%0d n1=%0d n2=%0d required=no pulse", d, cyc, n1, n2);
    end else begin
      e = q_res.pop_front();
      check("listo_dut", d, e.d);
      check("listo_cycle", cyc, e.cyc);
      check("numero1_bin", n1, e.n1);
      check("numero2_bin", n2, e.n2);
      check("error_bcd", er, e.err);
    end
  endtask

  // Monitor: compares every strobe/pulse the DUTs present against the queues.
  always @(negedge clk) begin
    if (leer1)  mon_leer(0, sel1, idx1);
    if (leer3)  mon_leer(1, sel3, idx3);
    if (listo1) mon_res(0, a1, b1, err1);
    if (listo3) mon_res(1, a3, b3, err3);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int n, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    mem[n][2] = d2;
    mem[n][1] = d1;
    mem[n][0] = d0;
  endtask

  task automatic expect_run(input int d, input int k, input int lat, input int n_leer,
                            input int n1, input int n2, input int er,
                            input bit con_listo, input int off_listo);
    for (int j = 0; j < n_leer; j++)
      q_rd.push_back('{d, j / 3, 2 - (j % 3), k + 1 + j * (2 + lat)});
    if (con_listo) q_res.push_back('{d, n1, n2, er, k + off_listo});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q_rd.size() != 0 || q_res.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("run_within_budget", (q_rd.size() == 0 && q_res.size() == 0), 1);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; cancelar = 1'b0; ini1 = 1'b0; ini3 = 1'b0;
    set_op(0, 0, 0, 0);
    set_op(1, 0, 0, 0);
    repeat (3) tick();
    check("rst_leer", leer1, 0);
    check("rst_sel", sel1, 0);
    check("rst_idx", idx1, 0);
    check("rst_n1", a1, 0);
    check("rst_n2", b1, 0);
    check("rst_ocupado", ocu1, 0);
    check("rst_listo", listo1, 0);
    check("rst_error", err1, 0);
    check("rst3_ocupado", ocu3, 0);
    rst = 1'b0;
    tick();

    // Basic run: 536 / 918
    set_op(0, 5, 3, 6); set_op(1, 9, 1, 8);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 6, 536, 918, 0, 1, 19);
    tick(); ini1 = 1'b0;
    check("ocupado_after_start", ocu1, 1);
    wait_done(40);
    check("hold_n1", a1, 536);
    check("hold_n2", b1, 918);
    check("idle_ocupado", ocu1, 0);

    // Extremes with iniciar held high: two back-to-back runs
    set_op(0, 0, 0, 0); set_op(1, 9, 9, 9);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 6, 0, 999, 0, 1, 19);
    expect_run(0, k + 20, 1, 6, 0, 999, 0, 1, 19);
    while (cyc < k + 21) tick();
    ini1 = 1'b0;
    wait_done(60);

    // Invalid digit in numero1 idx1
    set_op(0, 1, 4'hB, 2); set_op(1, 3, 3, 3);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 2, 0, 0, 1, 1, 7);
    tick(); ini1 = 1'b0;
    wait_done(40);
    check("err_sticky", err1, 1);
    check("err_n1_zero", a1, 0);
    check("err_n2_zero", b1, 0);

    // Valid run clears error_bcd: 701 / 42
    set_op(0, 7, 0, 1); set_op(1, 0, 4, 2);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 6, 701, 42, 0, 1, 19);
    tick(); ini1 = 1'b0;
    wait_done(40);

    // Cancel on the 4th leer cycle, with ignored iniciar pulses before it
    set_op(0, 2, 4, 7); set_op(1, 1, 0, 3);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 4, 0, 0, 0, 0, 0);
    tick();
    while (cyc < k + 10) begin
      ini1 = (cyc == k + 2 || cyc == k + 5);
      tick();
    end
    ini1 = 1'b0;
    check("midrun_n1", a1, 247);
    check("midrun_n2_held", b1, 42);
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    check("cancel_ocupado", ocu1, 0);
    check("cancel_n1", a1, 0);
    check("cancel_n2", b1, 0);
    check("cancel_leer", leer1, 0);
    check("cancel_error_kept", err1, 0);
    wait_done(10);
    repeat (20) tick();

    // Reset mid-run at cycle 10
    set_op(0, 1, 2, 3); set_op(1, 4, 5, 6);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 4, 0, 0, 0, 0, 0);
    tick(); ini1 = 1'b0;
    while (cyc < k + 10) tick();
    check("prerst_n1", a1, 123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_n1", a1, 0);
    check("midrst_n2", b1, 0);
    check("midrst_ocupado", ocu1, 0);
    check("midrst_sel", sel1, 0);
    check("midrst_idx", idx1, 0);
    check("midrst_leer", leer1, 0);
    wait_done(10);

    // LAT_LECTURA=3 instance: 804 / 65
    set_op(0, 8, 0, 4); set_op(1, 0, 6, 5);
    ini3 = 1'b1; k = cyc;
    expect_run(1, k, 3, 6, 804, 65, 0, 1, 31);
    tick(); ini3 = 1'b0;
    wait_done(60);

    // Recovery run on the LAT 1 instance
    set_op(0, 1, 2, 3); set_op(1, 4, 5, 6);
    ini1 = 1'b1; k = cyc;
    expect_run(0, k, 1, 6, 123, 456, 0, 1, 19);
    tick(); ini1 = 1'b0;
    wait_done(40);

    repeat (10) tick();
    check("queue_rd_empty", q_rd.size(), 0);
    check("queue_res_empty", q_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
